// File: rtl/x_in_to_single_out.sv
// Parallel-to-serial stage: accepts a NUM_INS-bit word over valid/ready and
// shifts it out one bit per out_en cycle, flagging the last bit and counting words.
module x_in_to_single_out #(
   parameter int NUM_INS   = 8,
   parameter bit LSB_FIRST = 1'b1,
   parameter int WCNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_INS-1:0] in_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               out_en,
   output logic               out,
   output logic               out_valid,
   output logic               out_last,
   output logic [WCNT_W-1:0]  word_cnt
);

   localparam int               CNT_W    = (NUM_INS > 1) ? $clog2(NUM_INS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INS - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   idx;
   logic [NUM_INS-1:0] shreg;
   logic               accept;
   logic               advance;

   assign idx       = LSB_FIRST ? cnt : (LAST_CNT - cnt);
   assign out_valid = (state == SHIFT);
   assign out       = out_valid ? shreg[idx] : 1'b0;
   assign out_last  = out_valid && (cnt == LAST_CNT);
   // Ready during the last bit lets the next word load on the same edge (zero gap).
   assign in_ready  = !rst && ((state == IDLE) || (out_last && out_en));
   assign accept    = in_valid && in_ready;
   assign advance   = out_valid && out_en;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         shreg    <= '0;
         word_cnt <= '0;
      end else begin
         if (advance && out_last) begin
            word_cnt <= word_cnt + WCNT_W'(1);
         end
         if (accept) begin
            shreg <= in_data;
            cnt   <= '0;
            state <= SHIFT;
         end else if (advance) begin
            if (out_last) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_x_in_to_single_out.sv
// Bench for x_in_to_single_out: three configurations (8/LSB, 8/MSB, 5/LSB with a
// 3-bit word counter) driven one at a time and checked against a bit scoreboard.
module tb_x_in_to_single_out;

   typedef struct {
      bit b;
      bit last;
   } exp_t;

   typedef struct {
      int         sel;
      logic [7:0] data;
      int         stall_at;
      int         stall_len;
      int         exp_valid;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       iv;
   logic       en;
   logic [7:0] din;
   int         sel;

   logic        rdy0, o0, ov0, ol0;
   logic        rdy1, o1, ov1, ol1;
   logic        rdy2, o2, ov2, ol2;
   logic [15:0] wc0, wc1;
   logic [2:0]  wc2;
   logic        iv0, iv1, iv2;

   logic        mv, mo, ml, mr;
   logic [15:0] mw;

   exp_t q[$];
   int   exp_wcnt[3];
   int   n_checks;
   int   n_fail;
   int   valid_cycles;
   int   pops;

   assign iv0 = iv && (sel == 0);
   assign iv1 = iv && (sel == 1);
   assign iv2 = iv && (sel == 2);

   x_in_to_single_out #(.NUM_INS(8), .LSB_FIRST(1'b1), .WCNT_W(16)) u_dut0 (
      .clk(clk), .rst(rst), .in_data(din), .in_valid(iv0), .in_ready(rdy0),
      .out_en(en), .out(o0), .out_valid(ov0), .out_last(ol0), .word_cnt(wc0));

   x_in_to_single_out #(.NUM_INS(8), .LSB_FIRST(1'b0), .WCNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .in_data(din), .in_valid(iv1), .in_ready(rdy1),
      .out_en(en), .out(o1), .out_valid(ov1), .out_last(ol1), .word_cnt(wc1));

   x_in_to_single_out #(.NUM_INS(5), .LSB_FIRST(1'b1), .WCNT_W(3)) u_dut2 (
      .clk(clk), .rst(rst), .in_data(din[4:0]), .in_valid(iv2), .in_ready(rdy2),
      .out_en(en), .out(o2), .out_valid(ov2), .out_last(ol2), .word_cnt(wc2));

   always_comb begin
      mv = ov0; mo = o0; ml = ol0; mr = rdy0; mw = wc0;
      case (sel)
         1: begin mv = ov1; mo = o1; ml = ol1; mr = rdy1; mw = wc1; end
         2: begin mv = ov2; mo = o2; ml = ol2; mr = rdy2; mw = 16'(wc2); end
         default: ;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (sel %0d, t=%0t): got %0h, expected %0h", name, sel, $time, act, exp);
      end
   endtask

   function automatic int wmask(input int s);
      return (s == 2) ? 32'h7 : 32'hFFFF;
   endfunction

   task automatic push_word(input logic [7:0] d);
      int   n   = (sel == 2) ? 5 : 8;
      bit   lsb = (sel != 1);
      int   idx;
      exp_t e;
      for (int i = 0; i < n; i++) begin
         idx    = lsb ? i : (n - 1 - i);
         e.b    = d[idx];
         e.last = (i == n - 1);
         q.push_back(e);
      end
   endtask

   // Mid-cycle monitor: compares the visible bit, then consumes it if out_en advances.
   task automatic mon();
      exp_t e;
      if (rst) begin
         check("in_ready_in_reset", mr, 1'b0);
      end else begin
         check("word_cnt", mw, exp_wcnt[sel] & wmask(sel));
         if (mv) begin
            valid_cycles++;
            if (q.size() == 0) begin
               check("unexpected_out_valid", mv, 1'b0);
            end else begin
               e = q[0];
               check("out_bit", mo, e.b);
               check("out_last", ml, e.last);
               check("in_ready_busy", mr, e.last && en);
               if (en) begin
                  if (e.last) exp_wcnt[sel]++;
                  void'(q.pop_front());
                  pops++;
               end
            end
         end else begin
            check("in_ready_idle", mr, 1'b1);
            check("out_idle", mo, 1'b0);
            check("out_last_idle", ml, 1'b0);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic run_word(input vec_t v);
      int guard;
      int stall_rem;
      sel          = v.sel;
      valid_cycles = 0;
      pops         = 0;
      stall_rem    = v.stall_len;
      din          = v.data;
      iv           = 1'b1;
      en           = 1'b1;
      push_word(v.data);
      tick();
      iv    = 1'b0;
      din   = ~v.data;
      guard = 0;
      while (q.size() > 0 && guard < 64) begin
         if (pops == v.stall_at && stall_rem > 0) begin
            en = 1'b0;
            stall_rem--;
         end else begin
            en = 1'b1;
         end
         tick();
         guard++;
      end
      en = 1'b1;
      check("drain_in_time", guard < 64, 1'b1);
      tick();
      check("valid_cycles", valid_cycles, v.exp_valid);
      check("back_to_idle", mv, 1'b0);
   endtask

   vec_t vecs[6];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      pops     = 0;
      foreach (exp_wcnt[i]) exp_wcnt[i] = 0;

      vecs[0] = '{0, 8'hA5, -1, 0, 8};
      vecs[1] = '{0, 8'hA5,  3, 3, 11};
      vecs[2] = '{1, 8'h80, -1, 0, 8};
      vecs[3] = '{2, 8'h13, -1, 0, 5};
      vecs[4] = '{1, 8'h3C,  0, 2, 10};
      vecs[5] = '{2, 8'h1F,  4, 1, 6};

      // Reset with a word offered: nothing may be captured.
      sel = 0; rst = 1'b1; iv = 1'b1; din = 8'hFF; en = 1'b1;
      @(posedge clk); #1;
      repeat (2) tick();
      check("reset_out_valid", ov0, 1'b0);
      check("reset_word_cnt", wc0, 16'd0);
      rst = 1'b0; iv = 1'b0;
      tick();
      check("post_reset_ready", rdy0, 1'b1);
      check("post_reset_no_capture", ov0, 1'b0);

      foreach (vecs[i]) run_word(vecs[i]);
      check("word_cnt_after_table", wc0, 16'd2);

      // Back-to-back 0x0F then 0xF0 with in_valid held.
      sel = 0; valid_cycles = 0;
      iv = 1'b1; din = 8'h0F; push_word(8'h0F);
      tick();
      din = 8'hF0; push_word(8'hF0);
      repeat (8) tick();
      iv = 1'b0;
      repeat (8) tick();
      tick();
      check("b2b_valid_cycles", valid_cycles, 16);
      check("b2b_queue_empty", q.size(), 0);
      check("b2b_word_cnt", wc0, 16'd4);

      // Reset while cnt = 4 of 0x3C discards the word.
      pops = 0;
      iv = 1'b1; din = 8'h3C; push_word(8'h3C);
      tick();
      iv = 1'b0;
      repeat (4) tick();
      check("midreset_pops", pops, 4);
      rst = 1'b1;
      q.delete();
      tick();
      rst = 1'b0;
      foreach (exp_wcnt[i]) exp_wcnt[i] = 0;
      check("midreset_out_valid", ov0, 1'b0);
      check("midreset_word_cnt", wc0, 16'd0);
      run_word('{0, 8'h01, -1, 0, 8});
      check("after_midreset_word_cnt", wc0, 16'd1);

      // Nine streamed 5-bit words wrap the 3-bit counter to 1.
      sel = 2; valid_cycles = 0;
      iv = 1'b1; din = 8'd3; push_word(8'd3);
      tick();
      for (int k = 1; k < 9; k++) begin
         din = 8'((k * 7 + 3) & 8'h1F);
         push_word(din);
         repeat (5) tick();
      end
      iv = 1'b0;
      repeat (5) tick();
      tick();
      check("wrap_valid_cycles", valid_cycles, 45);
      check("wrap_word_cnt", wc2, 3'd1);
      check("wrap_queue_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/x_in_to_single_out.md
Name: x_in_to_single_out

Overview:
- Parallel-to-serial stage that pairs with the single-bit-to-NUM_OUTS fan-out block.
- Accepts an NUM_INS-bit word through a valid/ready handshake and shifts it out one bit per enabled cycle on a single serial output.
- Flags each word's last bit and counts completed words.
- Used for utilization/loopback testing: fan-out feeds this block, or this block feeds the fan-out block's single input.

Parameters:
- NUM_INS, 8, word width in bits; legal range >= 1; non-power-of-2 values legal.
- LSB_FIRST, 1, 1 = bit 0 shifted first; 0 = bit NUM_INS-1 shifted first.
- WCNT_W, 16, width of the completed-word counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  NUM_INS  parallel word to serialize.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- out_en  input  1  downstream advance enable; low stalls shifting.
- out  output  1  current serial bit.
- out_valid  output  1  out carries a word bit.
- out_last  output  1  out is the final bit of the current word.
- word_cnt  output  WCNT_W  number of fully shifted words; wraps modulo 2^WCNT_W.

Behaviour:
- Reset is synchronous, active-high, clock clk. While rst = 1:
  - state = IDLE, cnt = 0, shreg = 0, word_cnt = 0.
  - in_ready forced 0; in_valid ignored.
- Reset has priority over every other event, including a mid-word reset: the partial word is discarded and no completion is counted.
- Cycle after reset release: in_ready = 1, out_valid = 0, out = 0, out_last = 0.
- cnt width = max(1, $clog2(NUM_INS)). Wrap uses an explicit compare cnt == NUM_INS-1, never natural overflow.
- Bit index: idx = cnt when LSB_FIRST = 1, else NUM_INS-1-cnt.
- Outputs, combinational from registered state:
  - out_valid = (state == SHIFT).
  - out = out_valid ? shreg[idx] : 0.
  - out_last = out_valid && cnt == NUM_INS-1.
  - in_ready = !rst && (state == IDLE || (out_last && out_en)).
- Accept = in_valid && in_ready. On accept at edge k:
  - shreg <= in_data, cnt <= 0, state <= SHIFT.
  - First bit appears on out in the cycle following edge k, so latency is 1 cycle.
- In SHIFT with out_en = 1 and not last: cnt <= cnt + 1.
- In SHIFT with out_en = 1 and last:
  - word_cnt <= word_cnt + 1.
  - If in_valid = 1, the new word loads in the same edge (back-to-back, zero-gap). Otherwise state <= IDLE.
- In SHIFT with out_en = 0: shreg, cnt, state and word_cnt hold; out is stable; in_ready = 0.
- In IDLE, out_en has no effect. in_data is ignored unless accepted, and changes to it after accept have no effect.
- NUM_INS = 1: every SHIFT cycle is last; with in_valid held and out_en = 1, words stream at 1 bit/cycle.
- word_cnt wraps from 2^WCNT_W-1 to 0 with no flag.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with in_valid = 1 and in_data = 0xFF -> in_ready = 0, out_valid = 0, word_cnt = 0. Release rst -> next cycle in_ready = 1 and no word was captured.
- Single word: NUM_INS = 8, LSB_FIRST = 1, in_data = 0xA5 pulsed one cycle, out_en = 1 -> out = 1,0,1,0,0,1,0,1 over 8 cycles starting the cycle after accept. out_last = 1 only on the 8th. Then out_valid = 0, in_ready = 1, word_cnt = 1.
- Back-to-back: in_valid held with 0x0F then 0xF0 -> 16 contiguous out_valid cycles, out = 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1. in_ready = 1 only on the two last-bit cycles (and initial IDLE). word_cnt = 2.
- Stall: 0xA5 with out_en = 0 for 3 cycles while cnt = 3 -> out holds 0, out_valid = 1, in_ready = 0, cnt unchanged. Sequence resumes at bit 4; total 11 out_valid cycles.
- MSB-first and odd width, run as two configurations:
  - LSB_FIRST = 0, NUM_INS = 8, 0x80 -> out = 1 then seven 0s.
  - NUM_INS = 5, LSB_FIRST = 1, 0x13 -> out = 1,1,0,0,1; out_last on the 5th bit; cnt returns to 0.
- Mid-word reset: rst pulsed while cnt = 4 of word 0x3C -> next cycle out_valid = 0, word_cnt = 0. A following word 0x01 serializes from bit 0 correctly.
